// File: rtl/serial_pkg.sv
// Shared definitions for the bit serializer: FSM encoding, default word width, parity helper.
package serial_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_PARITY = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;
    localparam int MAX_WIDTH     = 32;

    function automatic logic even_parity(input logic [MAX_WIDTH-1:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/shift_unit.sv
// Loadable shift register with a bit down-counter; last_o flags the final bit of a word.
module shift_unit #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load_i,
    input  logic             shift_i,
    input  logic [WIDTH-1:0] data_i,
    output logic             bit_o,
    output logic             last_o
);

    localparam int CW = $clog2(WIDTH);

    logic [WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    // Load has priority so a reload on the last bit replaces the shift.
    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (load_i) begin
            shift_d = data_i;
            cnt_d   = CW'(WIDTH - 1);
        end else if (shift_i) begin
            if (MSB_FIRST) shift_d = {shift_q[WIDTH-2:0], 1'b0};
            else           shift_d = {1'b0, shift_q[WIDTH-1:1]};
            if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bit_o  = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
    assign last_o = (cnt_q == '0);

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial stage with a one-word hold register for gapless back-to-back words.
// Define SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module bit_serializer
    import serial_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic             accept;
    logic             su_load, su_shift, su_bit, su_last;
    logic [WIDTH-1:0] su_data;

    assign data_ready = !hold_full_q;
    assign accept     = data_valid && data_ready;

    shift_unit #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk     (clk),
        .reset_n (reset_n),
        .load_i  (su_load),
        .shift_i (su_shift),
        .data_i  (su_data),
        .bit_o   (su_bit),
        .last_o  (su_last)
    );

    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        su_load     = 1'b0;
        su_shift    = 1'b0;
        su_data     = data_in;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    su_load = 1'b1;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                su_shift = 1'b1;
`ifdef SERIALIZER_PARITY_EN
                if (su_last) state_d = ST_PARITY;
                if (accept) begin
                    hold_d      = data_in;
                    hold_full_d = 1'b1;
                end
`else
                if (su_last) begin
                    // hold_full and accept are exclusive: data_ready is low while held
                    if (hold_full_q) begin
                        su_load     = 1'b1;
                        su_data     = hold_q;
                        hold_full_d = 1'b0;
                    end else if (accept) begin
                        su_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (accept) begin
                    hold_d      = data_in;
                    hold_full_d = 1'b1;
                end
`endif
            end
`ifdef SERIALIZER_PARITY_EN
            ST_PARITY: begin
                if (hold_full_q) begin
                    su_load     = 1'b1;
                    su_data     = hold_q;
                    hold_full_d = 1'b0;
                    state_d     = ST_SHIFT;
                end else if (accept) begin
                    su_load = 1'b1;
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
        end
    end

`ifdef SERIALIZER_PARITY_EN
    logic parity_q;

    // Parity is captured with the word so the hold register can be reused immediately.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)     parity_q <= 1'b0;
        else if (su_load) parity_q <= even_parity(MAX_WIDTH'(su_data));
    end
`endif

    always_comb begin
        serial_out = 1'b0;
        case (state_q)
            ST_SHIFT:  serial_out = su_bit;
`ifdef SERIALIZER_PARITY_EN
            ST_PARITY: serial_out = parity_q;
`endif
            default:   serial_out = 1'b0;
        endcase
    end

    assign serial_valid = (state_q != ST_IDLE);
    assign busy         = (state_q != ST_IDLE) || hold_full_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Scoreboard bench for bit_serializer: accepted words expand into an expected bit queue.
module tb_bit_serializer;

    localparam int W = 8;
`ifdef SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int P = W + PAR;

    logic         clk, reset_n;
    logic [W-1:0] data_in;
    logic         data_valid, data_ready, serial_out, serial_valid, busy;
    logic [3:0]   d4_in;
    logic         v4, ready4, out4, valid4, busy4;

    int n_cmp = 0;
    int n_err = 0;
    bit exp_q[$];

    bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .busy         (busy)
    );

    bit_serializer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
        .clk          (clk),
        .reset_n      (reset_n),
        .data_in      (d4_in),
        .data_valid   (v4),
        .data_ready   (ready4),
        .serial_out   (out4),
        .serial_valid (valid4),
        .busy         (busy4)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // A word is a list of bits in wire order, plus parity when enabled.
    logic acc;
    always begin
        @(negedge clk);
        acc = data_valid && data_ready && reset_n;
        @(posedge clk);
        if (acc && reset_n) begin
            for (int i = W - 1; i >= 0; i--) exp_q.push_back(data_in[i]);
            if (PAR != 0) exp_q.push_back(^data_in);
        end
    end

    // Outstanding bits must stream with no gaps; a held word exists once more than one word is queued.
    always @(negedge clk) begin
        int sz;
        if (reset_n) begin
            sz = exp_q.size();
            chk("serial_valid", {31'd0, serial_valid}, {31'd0, sz != 0});
            chk("data_ready", {31'd0, data_ready}, {31'd0, sz <= P});
            chk("busy", {31'd0, busy}, {31'd0, sz != 0});
            if (sz != 0) chk("serial_bit", {31'd0, serial_out}, {31'd0, exp_q.pop_front()});
            else         chk("idle_out_zero", {31'd0, serial_out}, 32'd0);
        end
    end

    task automatic send(input logic [W-1:0] w);
        int  n;
        logic rdy;
        n = 0;
        data_in    = w;
        data_valid = 1'b1;
        forever begin
            @(negedge clk);
            rdy = data_ready;
            @(posedge clk);
            if (rdy || n > 200) break;
            n++;
        end
        chk("accept_timeout", {31'd0, n <= 200}, 32'd1);
        #2 data_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            @(posedge clk);
            n++;
        end
        #2;
        chk("drain_timeout", {31'd0, n < 300}, 32'd1);
    endtask

    initial begin
        logic [3:0] w4;
        int gap;
        clk = 0; reset_n = 0; data_in = '0; data_valid = 0; d4_in = '0; v4 = 0;
        #1;
        chk("rst_ready", {31'd0, data_ready}, 32'd1);
        chk("rst_valid", {31'd0, serial_valid}, 32'd0);
        chk("rst_out", {31'd0, serial_out}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #2 reset_n = 1;

        send(8'hB0); drain();
        send(8'hA5); send(8'h3C); drain();
        // Raise valid exactly during the last bit with the hold register empty.
        send(8'h5A); idle(7); send(8'hC3); drain();
`ifdef SERIALIZER_PARITY_EN
        send(8'h07); drain();
        send(8'h03); drain();
        send(8'h07); send(8'h03); drain();
`endif

        w4 = 4'b0011;
        d4_in = w4; v4 = 1'b1;
        @(negedge clk);
        chk("lsb_ready", {31'd0, ready4}, 32'd1);
        @(posedge clk); #2 v4 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lsb_valid", {31'd0, valid4}, 32'd1);
            chk("lsb_bit", {31'd0, out4}, {31'd0, w4[i]});
        end
        @(negedge clk);
        chk("lsb_done", {31'd0, valid4}, 32'd0);
        @(posedge clk); #2;

        // Asynchronous reset with one word shifting and one held.
        send(8'hFF); send(8'h81); idle(2);
        #1 reset_n = 0;
        #1;
        chk("midrst_valid", {31'd0, serial_valid}, 32'd0);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_ready", {31'd0, data_ready}, 32'd1);
        chk("midrst_out", {31'd0, serial_out}, 32'd0);
        exp_q.delete();
        @(posedge clk); #2 reset_n = 1;
        idle(1);

        repeat (150) begin
            send(W'($urandom));
            gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : 0;
            if (gap != 0) idle(gap);
        end
        drain();
        idle(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
